// File: rtl/arp_ctrl.sv
// arp_ctrl: ARP request/reply sequencer with reply timeout.
// Define ARP_CTRL_RETRY_EN to re-send unanswered requests up to MAX_RETRY times.
module arp_ctrl #(
   parameter int TIMEOUT_CYC = 125000000,
   parameter int MAX_RETRY   = 3
) (
   input  logic        arp_tx_clk,
   input  logic        rstn,
   input  logic        user_req,
   input  logic [31:0] target_ip,
   input  logic        arp_rx_done,
   input  logic        arp_rx_op,
   input  logic [47:0] pc_mac,
   input  logic [31:0] pc_ip,
   input  logic        arp_tx_done,
   output logic        arp_tx_en,
   output logic        arp_tx_op,
   output logic [47:0] des_mac,
   output logic [31:0] des_ip,
   output logic        busy,
   output logic        resolved,
   output logic [47:0] peer_mac,
   output logic [31:0] peer_ip,
   output logic        timeout_err
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   typedef enum logic [2:0] {IDLE, RPL_SEND, RPL_WAIT, REQ_SEND, REQ_WAIT, WAIT_REPLY} state_t;
   state_t        r_state, w_next;
   logic [TW-1:0] r_timer;
   logic          r_pend_rpl, r_pend_req, r_outst;
   logic [47:0]   r_rpl_mac;
   logic [31:0]   r_rpl_ip, r_tgt_ip;
   logic          w_rx_req, w_rx_rpl, w_acc_req, w_pend_rpl, w_pend_req, w_tmo, w_retry, w_err;
   logic [47:0]   w_rpl_mac;
   logic [31:0]   w_rpl_ip, w_tgt_ip;

   assign w_rx_req   = arp_rx_done & arp_rx_op;
   assign w_rx_rpl   = arp_rx_done & ~arp_rx_op;
   assign w_acc_req  = user_req & (r_state == IDLE || r_state == RPL_SEND || r_state == RPL_WAIT);
   // Same-cycle events count as pending so IDLE reacts with one cycle of latency
   assign w_pend_rpl = r_pend_rpl | w_rx_req;
   assign w_pend_req = r_pend_req | w_acc_req;
   assign w_rpl_mac  = w_rx_req ? pc_mac : r_rpl_mac;
   assign w_rpl_ip   = w_rx_req ? pc_ip : r_rpl_ip;
   assign w_tgt_ip   = w_acc_req ? target_ip : r_tgt_ip;
   assign w_tmo      = r_state == WAIT_REPLY && r_timer == TW'(TIMEOUT_CYC - 1) && !w_rx_rpl;

`ifdef ARP_CTRL_RETRY_EN
   localparam int RW = $clog2(MAX_RETRY + 2);
   logic [RW-1:0] r_retry;
   assign w_retry = w_tmo && r_retry < RW'(MAX_RETRY);
   always_ff @(posedge arp_tx_clk)
      if (!rstn || (r_state == WAIT_REPLY && w_rx_rpl) || (w_tmo && !w_retry)) r_retry <= '0;
      else if (w_retry) r_retry <= r_retry + 1'b1;
`else
   assign w_retry = w_tmo & (MAX_RETRY < 0);
`endif
   assign w_err     = w_tmo & ~w_retry;
   assign arp_tx_en = r_state == RPL_SEND || r_state == REQ_SEND;
   assign busy      = r_state != IDLE;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:       w_next = w_pend_rpl ? RPL_SEND : w_pend_req ? REQ_SEND : IDLE;
         RPL_SEND:   w_next = RPL_WAIT;
         RPL_WAIT:   w_next = !arp_tx_done ? RPL_WAIT : r_outst ? WAIT_REPLY : IDLE;
         REQ_SEND:   w_next = REQ_WAIT;
         REQ_WAIT:   w_next = arp_tx_done ? WAIT_REPLY : REQ_WAIT;
         WAIT_REPLY: w_next = w_rx_rpl ? IDLE : w_retry ? REQ_SEND : w_err ? IDLE :
                              w_pend_rpl ? RPL_SEND : WAIT_REPLY;
         default:    w_next = IDLE;
      endcase
   end

   always_ff @(posedge arp_tx_clk) begin
      if (!rstn) begin
         r_state     <= IDLE;
         r_timer     <= '0;
         r_pend_rpl  <= 1'b0;
         r_pend_req  <= 1'b0;
         r_outst     <= 1'b0;
         r_rpl_mac   <= '0;
         r_rpl_ip    <= '0;
         r_tgt_ip    <= '0;
         arp_tx_op   <= 1'b0;
         des_mac     <= '0;
         des_ip      <= '0;
         resolved    <= 1'b0;
         peer_mac    <= '0;
         peer_ip     <= '0;
         timeout_err <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_pend_rpl  <= w_rx_req | (r_pend_rpl & r_state != RPL_SEND);
         r_pend_req  <= w_acc_req | (r_pend_req & r_state != REQ_SEND);
         r_outst     <= w_next == REQ_SEND || (r_outst && w_next != IDLE);
         // Timer only advances while staying in WAIT_REPLY, so it freezes across a reply
         r_timer     <= r_state == REQ_WAIT ? '0 :
                        (r_state == WAIT_REPLY && w_next == WAIT_REPLY) ? r_timer + 1'b1 : r_timer;
         timeout_err <= w_err;
         if (w_rx_req) begin
            r_rpl_mac <= pc_mac;
            r_rpl_ip  <= pc_ip;
         end
         if (w_acc_req) r_tgt_ip <= target_ip;
         if (w_next == RPL_SEND) begin
            arp_tx_op <= 1'b0;
            des_mac   <= w_rpl_mac;
            des_ip    <= w_rpl_ip;
         end else if (w_next == REQ_SEND) begin
            arp_tx_op <= 1'b1;
            des_mac   <= '1;
            des_ip    <= w_tgt_ip;
         end
         if (w_rx_rpl) begin
            resolved <= 1'b1;
            peer_mac <= pc_mac;
            peer_ip  <= pc_ip;
         end
      end
   end
endmodule

// File: tb/tb_arp_ctrl.sv
// tb_arp_ctrl: vector table, randomized scenario model and multi-cycle corner sequences for arp_ctrl.
module tb_arp_ctrl;
   localparam int TMO  = 100;
   localparam int MAXR = 2;
`ifdef ARP_CTRL_RETRY_EN
   localparam int FRAMES = MAXR + 1;
`else
   localparam int FRAMES = 1;
`endif
   localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

   logic        clk = 0, rstn = 0, user_req = 0, rx_done = 0, rx_op = 0, tx_done = 0;
   logic [31:0] target_ip = 0, pc_ip = 0;
   logic [47:0] pc_mac = 0;
   logic        tx_en, tx_op, busy, resolved, timeout_err;
   logic [47:0] des_mac, peer_mac;
   logic [31:0] des_ip, peer_ip;
   int          n_chk = 0, n_pass = 0;

   always #4 clk = ~clk;

   arp_ctrl #(.TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR)) dut (
      .arp_tx_clk(clk), .rstn(rstn), .user_req(user_req), .target_ip(target_ip),
      .arp_rx_done(rx_done), .arp_rx_op(rx_op), .pc_mac(pc_mac), .pc_ip(pc_ip),
      .arp_tx_done(tx_done), .arp_tx_en(tx_en), .arp_tx_op(tx_op), .des_mac(des_mac),
      .des_ip(des_ip), .busy(busy), .resolved(resolved), .peer_mac(peer_mac),
      .peer_ip(peer_ip), .timeout_err(timeout_err));

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic chk_i(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 0; user_req = 0; rx_done = 0; tx_done = 0;
      tick(); tick();
      rstn = 1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " tx_en"}, tx_en, 1'b0);
      chk({tag, " tx_op"}, tx_op, 1'b0);
      chk({tag, " des_mac"}, des_mac, 48'h0);
      chk({tag, " des_ip"}, des_ip, 32'h0);
      chk({tag, " busy"}, busy, 1'b0);
      chk({tag, " resolved"}, resolved, 1'b0);
      chk({tag, " peer_mac"}, peer_mac, 48'h0);
      chk({tag, " peer_ip"}, peer_ip, 32'h0);
      chk({tag, " timeout_err"}, timeout_err, 1'b0);
   endtask

   task automatic send_rx(input logic op, input logic [47:0] m, input logic [31:0] a);
      rx_done = 1; rx_op = op; pc_mac = m; pc_ip = a;
      tick();
      rx_done = 0;
   endtask

   task automatic send_user(input logic [31:0] a);
      user_req = 1; target_ip = a;
      tick();
      user_req = 0;
   endtask

   // Frame must be starting now; fields must hold until arp_tx_done is given
   task automatic frame(input logic op, input logic [47:0] m, input logic [31:0] a);
      chk("frame tx_en", tx_en, 1'b1);
      chk("frame op", tx_op, op);
      chk("frame des_mac", des_mac, m);
      chk("frame des_ip", des_ip, a);
      chk("frame busy", busy, 1'b1);
      repeat ($urandom_range(1, 4)) tick();
      chk("hold tx_en low", tx_en, 1'b0);
      chk("hold op", tx_op, op);
      chk("hold des_mac", des_mac, m);
      chk("hold des_ip", des_ip, a);
      tx_done = 1;
      tick();
      tx_done = 0;
   endtask

   task automatic count_until(input int budget, output int n, output bit is_err);
      n = -1;
      is_err = 0;
      for (int k = 1; k <= budget; k++) begin
         tick();
         if (tx_en || timeout_err) begin
            n = k;
            is_err = timeout_err;
            return;
         end
      end
   endtask

   typedef struct {
      bit          user;
      logic [47:0] mac;
      logic [31:0] ip;
      logic        exp_op;
      logic [47:0] exp_mac;
      logic [31:0] exp_ip;
      logic [47:0] rpl_mac;
      logic [31:0] rpl_ip;
   } vec_t;
   vec_t vecs[4];

   logic [47:0] m, m2, mdl_peer_mac;
   logic [31:0] a, a2, mdl_peer_ip;
   logic        mdl_resolved;
   int          kind, n;
   bit          e;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b1, 48'h0, 32'hC0A80102, 1'b1, BCAST, 32'hC0A80102, 48'h001122334455, 32'hC0A80102};
      vecs[1] = '{1'b0, 48'hAABBCCDDEEFF, 32'hC0A80103, 1'b0, 48'hAABBCCDDEEFF, 32'hC0A80103, 48'h0, 32'h0};
      vecs[2] = '{1'b1, 48'h0, 32'h0A000001, 1'b1, BCAST, 32'h0A000001, 48'h0200DEADBEEF, 32'h0A000001};
      vecs[3] = '{1'b0, 48'h010203040506, 32'hFFFFFFFF, 1'b0, 48'h010203040506, 32'hFFFFFFFF, 48'h0, 32'h0};

      do_reset();
      chk_reset("reset");

      foreach (vecs[i]) begin
         if (vecs[i].user) send_user(vecs[i].ip);
         else send_rx(1'b1, vecs[i].mac, vecs[i].ip);
         frame(vecs[i].exp_op, vecs[i].exp_mac, vecs[i].exp_ip);
         if (vecs[i].user) begin
            chk("vec wait busy", busy, 1'b1);
            repeat (5) tick();
            send_rx(1'b0, vecs[i].rpl_mac, vecs[i].rpl_ip);
            chk("vec resolved", resolved, 1'b1);
            chk("vec peer_mac", peer_mac, vecs[i].rpl_mac);
            chk("vec peer_ip", peer_ip, vecs[i].rpl_ip);
         end
         chk("vec idle busy", busy, 1'b0);
      end

      // Randomized scenarios against a transaction-level model of the peer table
      do_reset();
      mdl_resolved = 0; mdl_peer_mac = 0; mdl_peer_ip = 0;
      for (int it = 0; it < 40; it++) begin
         kind = $urandom_range(0, 2);
         m = {16'($urandom), $urandom};
         a = $urandom;
         repeat ($urandom_range(0, 3)) tick();
         if (kind == 0) begin
            send_rx(1'b1, m, a);
            frame(1'b0, m, a);
         end else if (kind == 1) begin
            send_user(a);
            frame(1'b1, BCAST, a);
            repeat ($urandom_range(0, 50)) tick();
            if ($urandom_range(0, 1) == 1) begin
               m2 = {16'($urandom), $urandom};
               a2 = $urandom;
               send_rx(1'b1, m2, a2);
               frame(1'b0, m2, a2);
               chk("rnd back to wait", busy, 1'b1);
            end
            m = {16'($urandom), $urandom};
            a = $urandom;
            send_rx(1'b0, m, a);
            mdl_resolved = 1; mdl_peer_mac = m; mdl_peer_ip = a;
         end else begin
            send_rx(1'b0, m, a);
            mdl_resolved = 1; mdl_peer_mac = m; mdl_peer_ip = a;
         end
         chk("rnd busy", busy, 1'b0);
         chk("rnd resolved", resolved, mdl_resolved);
         chk("rnd peer_mac", peer_mac, mdl_peer_mac);
         chk("rnd peer_ip", peer_ip, mdl_peer_ip);
      end

      // No reply: retries (if built) then one timeout_err, each TMO cycles after the frame
      do_reset();
      send_user(32'hC0A80199);
      frame(1'b1, BCAST, 32'hC0A80199);
      for (int f = 1; f <= FRAMES; f++) begin
         count_until(2 * TMO, n, e);
         chk_i("timeout gap", n, TMO);
         if (f < FRAMES) begin
            chk("retry is frame", e, 1'b0);
            frame(1'b1, BCAST, 32'hC0A80199);
         end else begin
            chk("final is timeout_err", e, 1'b1);
            chk("timeout busy", busy, 1'b0);
            chk("timeout resolved", resolved, 1'b0);
            tick();
            chk("timeout_err pulse", timeout_err, 1'b0);
         end
      end

      // Reply sent from WAIT_REPLY at timer 40: timer resumes at 40
      do_reset();
      send_user(32'hC0A80150);
      frame(1'b1, BCAST, 32'hC0A80150);
      repeat (40) tick();
      send_rx(1'b1, 48'h0A0B0C0D0E0F, 32'hC0A80177);
      frame(1'b0, 48'h0A0B0C0D0E0F, 32'hC0A80177);
      chk("freeze back busy", busy, 1'b1);
      count_until(2 * TMO, n, e);
      chk_i("freeze remaining", n, TMO - 40);
      chk("freeze event kind", e, FRAMES == 1);

      // Same-cycle request and user_req in IDLE: reply first, then request
      do_reset();
      user_req = 1; target_ip = 32'h0A0A0A0A;
      send_rx(1'b1, 48'h112233445566, 32'h0A0A0A0B);
      user_req = 0;
      frame(1'b0, 48'h112233445566, 32'h0A0A0A0B);
      count_until(10, n, e);
      chk_i("second frame latency", n, 1);
      frame(1'b1, BCAST, 32'h0A0A0A0A);

      // Reply coincident with the timeout cycle
      do_reset();
      send_user(32'hC0A80160);
      frame(1'b1, BCAST, 32'hC0A80160);
      repeat (TMO - 1) tick();
      send_rx(1'b0, 48'hCAFEBABE0001, 32'hC0A80160);
      chk("coincide timeout_err", timeout_err, 1'b0);
      chk("coincide resolved", resolved, 1'b1);
      chk("coincide peer_mac", peer_mac, 48'hCAFEBABE0001);
      chk("coincide busy", busy, 1'b0);
      count_until(5, n, e);
      chk_i("coincide no event", n, -1);

      // Reset while in REQ_WAIT with peer already known
      do_reset();
      send_rx(1'b0, 48'h00000000BEEF, 32'h01010101);
      send_user(32'h02020202);
      chk("pre-reset tx_en", tx_en, 1'b1);
      tick();
      chk("pre-reset busy", busy, 1'b1);
      rstn = 0;
      tick();
      chk_reset("mid-frame reset");
      rstn = 1;
      count_until(10, n, e);
      chk_i("post-reset no event", n, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
